// File: rtl/frame_serializer_if.sv
// Frame capture and byte-stream link of the frame serializer.
// slave is the serializer side, master is the frame source / USB transmit side.
interface frame_serializer_if #(
  parameter int PAYLOAD_BYTES = 64
);
  localparam int FRAME_W = 8 * (PAYLOAD_BYTES + 2);

  logic [FRAME_W-1:0] frame_in;
  logic               load;
  logic               tx_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               busy;
  logic               frame_done;
  logic               overrun;

  modport master (
    output frame_in, load, tx_ready,
    input  tx_data, tx_valid, busy, frame_done, overrun
  );

  modport slave (
    input  frame_in, load, tx_ready,
    output tx_data, tx_valid, busy, frame_done, overrun
  );
endinterface

// File: rtl/frame_serializer.sv
// Captures one averaged frame and streams its payload a byte at a time,
// followed by the complemented CRC-16/USB of the payload (low byte first).
module frame_serializer #(
  parameter int PAYLOAD_BYTES = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  frame_serializer_if.slave bus
);
  localparam int FRAME_W = 8 * (PAYLOAD_BYTES + 2);
  localparam int PAY_W   = 8 * PAYLOAD_BYTES;
  localparam int IDX_W   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_CRC_LO,
    S_CRC_HI,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PAY_W-1:0]   shadow_q;
  logic [15:0]        crc_q;
  logic [IDX_W-1:0]   idx_q;
  logic               overrun_q;

  logic               capture;
  logic               xfer;
  logic               tx_valid;
  logic               busy;
  logic               frame_done;
  logic [7:0]         tx_data;
  logic               unused_lsbs;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign xfer        = tx_valid && bus.tx_ready;
  assign unused_lsbs = ^bus.frame_in[15:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    tx_valid   = 1'b0;
    tx_data    = '0;
    busy       = 1'b1;
    frame_done = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.load) begin
          capture = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shadow_q[PAY_W-1 -: 8];
        if (bus.tx_ready && (idx_q == LAST_IDX)) state_d = S_CRC_LO;
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[7:0];
        if (bus.tx_ready) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[15:8];
        if (bus.tx_ready) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Shadow shifts left on each payload transfer so the current byte is always
  // the top byte; idx only tracks when the payload is exhausted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow_q  <= '0;
      crc_q     <= '1;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.load && (state_q != S_IDLE);
      if (capture) begin
        shadow_q <= bus.frame_in[FRAME_W-1:16];
        crc_q    <= '1;
        idx_q    <= '0;
      end else if (xfer && (state_q == S_SEND)) begin
        shadow_q <= shadow_q << 8;
        crc_q    <= crc16_byte(crc_q, shadow_q[PAY_W-1 -: 8]);
        idx_q    <= idx_q + 1'b1;
      end
    end
  end

  assign bus.tx_data    = tx_data;
  assign bus.tx_valid   = tx_valid;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: queue-based frame model checked every cycle on a
// 64-byte instance, plus literal checks of the CRC-16/USB check string on a 9-byte instance.
module tb_frame_serializer;
  localparam int P   = 64;
  localparam int FW  = 8 * (P + 2);
  localparam int P9  = 9;
  localparam int FW9 = 8 * (P9 + 2);

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  frame_serializer_if #(.PAYLOAD_BYTES(P))  bus64 ();
  frame_serializer_if #(.PAYLOAD_BYTES(P9)) bus9 ();

  frame_serializer #(.PAYLOAD_BYTES(P))  dut   (.clk(clk), .n_rst(n_rst), .bus(bus64));
  frame_serializer #(.PAYLOAD_BYTES(P9)) dut9  (.clk(clk), .n_rst(n_rst), .bus(bus9));

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout(input string name, input int unsigned limit);
    total++;
    bad++;
    $display("FAIL %s: event not seen within %0d cycles", name, limit);
  endtask

  // ---------------- reference model ----------------
  // Byte k of the transmitted stream: payload bytes MSB-first, then ~CRC low, ~CRC high.
  function automatic logic [7:0] frame_byte(input logic [FW-1:0] f, input int k);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    if (k < P) return f[FW-1-8*k -: 8];
    c = 16'hFFFF;
    for (int j = 0; j < P; j++) begin
      b = f[FW-1-8*j -: 8];
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ b[i];
        c  = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
      end
    end
    return (k == P) ? ~c[7:0] : ~c[15:8];
  endfunction

  function automatic logic [FW-1:0] ramp_frame(input logic [15:0] lo);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < P; k++) f[FW-1-8*k -: 8] = 8'(k);
    f[15:0] = lo;
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < FW / 8; k++) f[8*k +: 8] = 8'($urandom);
    return f;
  endfunction

  logic [7:0] exp_q[$];
  bit         m_done;
  bit         m_ovr;
  bit         m_busy_now;
  bit         m_next_done;
  logic [FW-1:0] m_frame;

  initial begin
    m_done = 0;
    m_ovr  = 0;
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) begin
        exp_q.delete();
        m_done = 0;
        m_ovr  = 0;
      end else begin
        m_busy_now  = (exp_q.size() != 0) || m_done;
        m_next_done = 0;
        m_ovr       = bus64.load && m_busy_now;
        if (exp_q.size() != 0 && bus64.tx_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_next_done = 1;
        end
        m_done = m_next_done;
        if (bus64.load && !m_busy_now) begin
          m_frame = bus64.frame_in;
          for (int k = 0; k < P + 2; k++) exp_q.push_back(frame_byte(m_frame, k));
        end
      end
    end
  end

  // Per-cycle compare: {tx_valid, tx_data, busy, frame_done, overrun}
  logic [11:0] exp_v, got_v;
  always @(negedge clk) begin
    exp_v = {exp_q.size() != 0,
             (exp_q.size() != 0) ? exp_q[0] : 8'h00,
             (exp_q.size() != 0) || m_done,
             m_done,
             m_ovr};
    got_v = {bus64.tx_valid, bus64.tx_data, bus64.busy, bus64.frame_done, bus64.overrun};
    check("cycle_outputs", 32'(got_v), 32'(exp_v));
  end

  // Transfer and overrun recorder
  logic [7:0] got_q[$];
  int ovr_cnt = 0;
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (bus64.tx_valid && bus64.tx_ready) got_q.push_back(bus64.tx_data);
      if (bus64.overrun) ovr_cnt++;
    end
  end

  bit rnd_ready = 0;
  initial forever begin
    @(posedge clk);
    #1;
    bus64.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int unsigned load_cyc;

  task automatic send_load(input logic [FW-1:0] f);
    @(posedge clk);
    #1;
    bus64.load     = 1'b1;
    bus64.frame_in = f;
    load_cyc       = cyc;
    @(posedge clk);
    #1;
    bus64.load     = 1'b0;
    bus64.frame_in = rand_frame();
  endtask

  task automatic wait_done(input string name, input int unsigned limit, output int unsigned at);
    at = 0;
    for (int unsigned n = 0; n < limit; n++) begin
      @(negedge clk);
      if (bus64.frame_done === 1'b1) begin
        at = cyc;
        return;
      end
    end
    timeout(name, limit);
  endtask

  task automatic wait_xfers(input string name, input int target, input int unsigned limit);
    for (int unsigned n = 0; n < limit; n++) begin
      @(negedge clk);
      if (got_q.size() >= target) return;
    end
    timeout(name, limit);
  endtask

  task automatic check_ramp_stream(input string name, input int base);
    int mism;
    logic [FW-1:0] rf;
    rf   = ramp_frame(16'h0000);
    mism = 0;
    check({name, "_len"}, 32'(got_q.size() - base), 32'(P + 2));
    if (got_q.size() >= base + P + 2)
      for (int k = 0; k < P + 2; k++)
        if (got_q[base + k] !== frame_byte(rf, k)) mism++;
    check({name, "_bytes"}, 32'(mism), 32'd0);
  endtask

  logic [7:0] exp9 [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                            8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
  logic [7:0] q9[$];
  int unsigned l9, first9, last9, done9;
  int unsigned dcyc;
  int base, ovr0;

  initial begin
    n_rst          = 1'b0;
    bus64.load     = 1'b0;
    bus64.frame_in = '0;
    bus64.tx_ready = 1'b1;
    bus9.load      = 1'b0;
    bus9.frame_in  = '0;
    bus9.tx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bus64.tx_valid, bus64.tx_data, bus64.busy, bus64.frame_done, bus64.overrun}), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // 9-byte payload "123456789": literal stream and timing
    @(posedge clk);
    #1;
    bus9.load     = 1'b1;
    bus9.frame_in = {72'h313233343536373839, 16'h5A5A};
    l9            = cyc;
    @(posedge clk);
    #1;
    bus9.load     = 1'b0;
    bus9.frame_in = '1;
    first9 = 0; last9 = 0; done9 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus9.tx_valid && bus9.tx_ready) begin
        if (q9.size() == 0) first9 = cyc;
        last9 = cyc;
        q9.push_back(bus9.tx_data);
      end
      if (bus9.frame_done) done9 = cyc;
    end
    check("t1_count", 32'(q9.size()), 32'd11);
    for (int k = 0; k < 11; k++)
      if (k < q9.size()) check($sformatf("t1_byte%0d", k), 32'(q9[k]), 32'(exp9[k]));
    check("t1_first_cycle", first9 - l9, 32'd1);
    check("t1_last_cycle", last9 - l9, 32'd11);
    check("t1_done_cycle", done9 - l9, 32'd12);

    // Ramp payload, ready held high, low 16 bits all ones
    base = got_q.size();
    send_load(ramp_frame(16'hFFFF));
    wait_done("t2_done", 200, dcyc);
    check("t2_done_latency", dcyc - load_cyc, 32'd67);
    @(negedge clk);
    check("t2_busy_after", 32'(bus64.busy), 32'd0);
    if (got_q.size() >= base + P) begin
      check("t2_first_byte", 32'(got_q[base]), 32'h00);
      check("t2_last_payload", 32'(got_q[base + P - 1]), 32'h3F);
    end
    check_ramp_stream("t2_stream", base);

    // Same frame with random back-pressure and low 16 bits zero
    rnd_ready = 1;
    base = got_q.size();
    send_load(ramp_frame(16'h0000));
    wait_done("t3_done", 2000, dcyc);
    rnd_ready = 0;
    check_ramp_stream("t3_stream", base);

    // Overrun at byte 10, then a load right after frame_done
    base = got_q.size();
    ovr0 = ovr_cnt;
    send_load(rand_frame());
    wait_xfers("t4_byte10", base + 10, 200);
    send_load(rand_frame());
    wait_done("t4_done1", 200, dcyc);
    check("t4_overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    send_load(ramp_frame(16'hAAAA));
    @(negedge clk);
    check("t4_frame2_started", 32'({bus64.busy, bus64.tx_valid}), 32'b11);
    wait_done("t4_done2", 200, dcyc);

    // Reset mid-frame, then a clean restart
    base = got_q.size();
    send_load(ramp_frame(16'h1234));
    wait_xfers("t5_byte20", base + 20, 200);
    #2;
    n_rst = 1'b0;
    #1;
    check("t5_reset_outputs",
          32'({bus64.tx_valid, bus64.tx_data, bus64.busy, bus64.frame_done, bus64.overrun}), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    base = got_q.size();
    send_load(ramp_frame(16'hFFFF));
    wait_done("t5_done", 200, dcyc);
    check("t5_done_latency", dcyc - load_cyc, 32'd67);
    check_ramp_stream("t5_stream", base);

    // Random soak: random frames, random loads (including while busy), random ready
    rnd_ready = 1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      bus64.load     = ($urandom_range(0, 49) == 0);
      bus64.frame_in = rand_frame();
    end
    bus64.load = 1'b0;
    rnd_ready  = 0;
    repeat (80) @(negedge clk);
    check("soak_idle_at_end", 32'(bus64.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
